// File: rtl/cutie_params.sv
// Shared CUTIE parameters, the ternary activation type and trit helpers.
package cutie_params;

    localparam int IMAGEWIDTH          = 64;
    localparam int POOLING_FIFODEPTH   = IMAGEWIDTH / 2;
    localparam int THRESHOLD_FIFODEPTH = 8;
    localparam int LAYER_FIFODEPTH     = 16;

    typedef logic signed [1:0] trit_t;

    localparam trit_t T_NEG  = 2'sb11;
    localparam trit_t T_ZERO = 2'sb00;
    localparam trit_t T_POS  = 2'sb01;

    // 2'b10 is not a legal trit; fold it onto -1 so it can never win a max
    function automatic trit_t trit_sanitize(input trit_t a);
        trit_t r;
        if (a == 2'sb10) begin
            r = T_NEG;
        end else begin
            r = a;
        end
        return r;
    endfunction

    function automatic trit_t trit_max(input trit_t a, input trit_t b);
        trit_t a_s;
        trit_t b_s;
        a_s = trit_sanitize(a);
        b_s = trit_sanitize(b);
        return (a_s > b_s) ? a_s : b_s;
    endfunction

endpackage

// File: rtl/ocu_pool_fifo.sv
// Small registered FIFO with occupancy count; shared by the pooling, threshold
// and layer buffers. Pushes while full and pops while empty are ignored.
module ocu_pool_fifo #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 2,
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNTW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [PTRW-1:0]  rd_ptr_d;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        logic [PTRW-1:0] r;
        if (p == PTRW'(DEPTH - 1)) begin
            r = {PTRW{1'b0}};
        end else begin
            r = p + PTRW'(1);
        end
        return r;
    endfunction

    assign full_o    = (count_q == CNTW'(DEPTH));
    assign empty_o   = (count_q == {CNTW{1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o & ~clear_i;
    assign do_pop_s  = pop_i & ~empty_o & ~clear_i;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = {PTRW{1'b0}};
            rd_ptr_d = {PTRW{1'b0}};
            count_d  = {CNTW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTRW{1'b0}};
            rd_ptr_q <= {PTRW{1'b0}};
            count_q  <= {CNTW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ocu_pool_unit.sv
// Per-OCU 2x2/stride-2 ternary max-pooling stage with bypass. Pixels arrive in
// raster order; even rows park half-window maxima in a FIFO, odd rows complete them.
module ocu_pool_unit #(
    parameter int IMAGEWIDTH = cutie_params::IMAGEWIDTH,
    parameter int FIFODEPTH  = cutie_params::POOLING_FIFODEPTH,
    parameter int WIDTHW     = $clog2(IMAGEWIDTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              pooling_enable_i,
    input  logic [WIDTHW-1:0] image_width_i,
    input  logic              valid_i,
    input  logic [1:0]        data_i,
    output logic              valid_o,
    output logic [1:0]        data_o,
    output logic              overflow_o
);

    import cutie_params::*;

    localparam int CNTW = $clog2(FIFODEPTH + 1);

    logic [WIDTHW-1:0] col_q, col_d;
    logic              rp_q, rp_d;
    logic              pool_q, pool_d;
    trit_t             h_q, h_d;
    logic              valid_q, valid_d;
    logic [1:0]        data_q, data_d;
    logic              ovf_q, ovf_d;

    logic              idle_s;
    logic              pool_s;
    logic              last_col_s;
    logic              odd_col_s;
    trit_t             pix_s;
    trit_t             pair_max_s;
    trit_t             fifo_head_s;
    trit_t             win_max_s;
    logic              push_s;
    logic              pop_s;
    logic [1:0]        fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNTW-1:0]   fifo_count_s;

    // Mode is only allowed to change at an image boundary, so it is latched
    // while the window position is at the top-left corner.
    assign idle_s     = (col_q == {WIDTHW{1'b0}}) && !rp_q;
    assign pool_s     = idle_s ? pooling_enable_i : pool_q;
    assign last_col_s = (col_q == (image_width_i - WIDTHW'(1)));
    assign odd_col_s  = col_q[0];
    assign pix_s      = trit_t'(data_i);
    assign pair_max_s = trit_max(h_q, pix_s);
    assign fifo_head_s = fifo_empty_s ? T_NEG : trit_t'(fifo_rdata_s);
    assign win_max_s  = trit_max(pair_max_s, fifo_head_s);
    assign push_s     = valid_i && !clear_i && pool_s && odd_col_s && !rp_q;
    assign pop_s      = valid_i && !clear_i && pool_s && odd_col_s && rp_q;

    ocu_pool_fifo #(
        .DEPTH (FIFODEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (pair_max_s),
        .data_o  (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Window position, hold register, output and error next-state
    always_comb begin
        col_d   = col_q;
        rp_d    = rp_q;
        pool_d  = pool_s;
        h_d     = h_q;
        valid_d = 1'b0;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            col_d   = {WIDTHW{1'b0}};
            rp_d    = 1'b0;
            pool_d  = 1'b0;
            h_d     = T_ZERO;
            valid_d = 1'b0;
            data_d  = 2'b00;
            ovf_d   = 1'b0;
        end else begin
            if (valid_i) begin
                if (last_col_s) begin
                    col_d = {WIDTHW{1'b0}};
                    rp_d  = ~rp_q;
                end else begin
                    col_d = col_q + WIDTHW'(1);
                    rp_d  = rp_q;
                end
                if (!pool_s) begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                end else if (!odd_col_s) begin
                    h_d = pix_s;
                end else if (rp_q) begin
                    valid_d = 1'b1;
                    data_d  = win_max_s;
                end else begin
                    h_d = h_q;
                end
            end else begin
                valid_d = 1'b0;
            end
            // A count beyond depth can only mean corrupted FIFO state
            if ((push_s && fifo_full_s) || (pop_s && fifo_empty_s) ||
                (fifo_count_s > CNTW'(FIFODEPTH))) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q   <= {WIDTHW{1'b0}};
            rp_q    <= 1'b0;
            pool_q  <= 1'b0;
            h_q     <= T_ZERO;
            valid_q <= 1'b0;
            data_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            rp_q    <= rp_d;
            pool_q  <= pool_d;
            h_q     <= h_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ocu_pool_unit.sv
// Self-checking bench for ocu_pool_unit: directed vector table, timing/clear/
// overflow/reset sequences, and randomized images against a window-max model.
module tb_ocu_pool_unit;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic       pooling_enable_i;
    logic [6:0] image_width_i;
    logic       valid_i;
    logic [1:0] data_i;
    logic       valid_o;
    logic [1:0] data_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    logic [1:0] outq[$];
    logic [1:0] expq[$];
    logic [1:0] pixq[$];

    typedef struct packed {
        logic        pool;
        logic [6:0]  width;
        logic [3:0]  npix;
        logic [15:0] pix;
        logic [2:0]  nexp;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    ocu_pool_unit dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .pooling_enable_i (pooling_enable_i),
        .image_width_i    (image_width_i),
        .valid_i          (valid_i),
        .data_i           (data_i),
        .valid_o          (valid_o),
        .data_o           (data_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni && valid_o) outq.push_back(data_o);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int tv(input logic [1:0] p);
        case (p)
            2'b01:   return 1;
            2'b00:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic logic [1:0] te(input int v);
        if (v > 0) return 2'b01;
        if (v == 0) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [15:0] p8(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [7:0] e4(input logic [1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Reference: every 2x2 window of complete row pairs, or identity in bypass
    task automatic build_expected(input bit pool, input int w);
        expq.delete();
        if (!pool) begin
            foreach (pixq[i]) expq.push_back(pixq[i]);
        end else begin
            for (int r = 1; r < pixq.size() / w; r += 2) begin
                for (int j = 0; j < w / 2; j++) begin
                    int m = -1;
                    for (int dr = -1; dr <= 0; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            int v;
                            v = tv(pixq[(r + dr) * w + 2 * j + dc]);
                            if (v > m) m = v;
                        end
                    end
                    expq.push_back(te(m));
                end
            end
        end
    endtask

    task automatic do_clear(input logic pool, input int w);
        @(negedge clk_i);
        valid_i          = 1'b0;
        clear_i          = 1'b1;
        pooling_enable_i = pool;
        image_width_i    = 7'(w);
        @(negedge clk_i);
        clear_i = 1'b0;
    endtask

    task automatic px(input logic [1:0] d);
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
        end
    endtask

    task automatic run_stream(input int gapmax);
        foreach (pixq[i]) begin
            px(pixq[i]);
            idle($urandom_range(0, gapmax));
        end
        idle(4);
    endtask

    task automatic compare_out(input string name);
        chk({name, " count"}, outq.size(), expq.size());
        for (int i = 0; i < outq.size() && i < expq.size(); i++) chk(name, outq[i], expq[i]);
        outq.delete();
        expq.delete();
        pixq.delete();
    endtask

    task automatic load_vec(input vec_t v);
        pixq.delete();
        expq.delete();
        for (int i = 0; i < int'(v.npix); i++) pixq.push_back(v.pix[2*i +: 2]);
        for (int i = 0; i < int'(v.nexp); i++) expq.push_back(v.exp[2*i +: 2]);
    endtask

    initial begin
        vecs[0] = '{1'b0, 7'd4, 4'd4, p8(2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00),
                    3'd4, e4(2'b01, 2'b00, 2'b11, 2'b01)};
        vecs[1] = '{1'b1, 7'd4, 4'd8, p8(2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11),
                    3'd2, e4(2'b01, 2'b00, 2'b00, 2'b00)};
        vecs[2] = '{1'b1, 7'd2, 4'd8, p8(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11),
                    3'd2, e4(2'b11, 2'b01, 2'b00, 2'b00)};
        vecs[3] = '{1'b1, 7'd4, 4'd8, p8(2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10),
                    3'd2, e4(2'b11, 2'b11, 2'b00, 2'b00)};
        vecs[4] = '{1'b1, 7'd3, 4'd6, p8(2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00),
                    3'd1, e4(2'b11, 2'b00, 2'b00, 2'b00)};
        vecs[5] = '{1'b1, 7'd2, 4'd4, p8(2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00),
                    3'd1, e4(2'b00, 2'b00, 2'b00, 2'b00)};

        rst_ni           = 1'b0;
        clear_i          = 1'b0;
        pooling_enable_i = 1'b0;
        image_width_i    = 7'd4;
        valid_i          = 1'b0;
        data_i           = 2'b00;
        #1;
        chk("reset valid_o", valid_o, 1'b0);
        chk("reset data_o", data_o, 2'b00);
        chk("reset overflow_o", overflow_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed table
        foreach (vecs[k]) begin
            do_clear(vecs[k].pool, int'(vecs[k].width));
            load_vec(vecs[k]);
            run_stream(0);
            compare_out($sformatf("vec%0d", k));
            chk($sformatf("vec%0d overflow", k), overflow_o, 1'b0);
        end

        // Same pooled image with idle gaps between pixels
        do_clear(1'b1, 4);
        load_vec(vecs[1]);
        run_stream(3);
        compare_out("gapped pool w4");

        // Output timing: one cycle after pixels 6 and 8, single-cycle pulses
        do_clear(1'b1, 4);
        px(2'b11); px(2'b01); px(2'b00); px(2'b00);
        px(2'b11); px(2'b11);
        chk("lat before p6 valid", valid_o, 1'b0);
        px(2'b00);
        chk("lat after p6 valid", valid_o, 1'b1);
        chk("lat after p6 data", data_o, 2'b01);
        px(2'b11);
        chk("lat after p7 valid", valid_o, 1'b0);
        idle(1);
        chk("lat after p8 valid", valid_o, 1'b1);
        chk("lat after p8 data", data_o, 2'b00);
        idle(1);
        chk("lat pulse end valid", valid_o, 1'b0);
        chk("lat data hold", data_o, 2'b00);
        idle(3);
        chk("lat output count", outq.size(), 2);
        outq.delete();

        // Clear mid-image, coinciding with a valid pixel, then a fresh all-zero image
        do_clear(1'b1, 4);
        px(2'b01); px(2'b01); px(2'b01);
        @(negedge clk_i);
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 2'b01;
        @(negedge clk_i);
        clear_i = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 8; i++) pixq.push_back(2'b00);
        expq.push_back(2'b00);
        expq.push_back(2'b00);
        run_stream(0);
        compare_out("after clear");
        chk("after clear overflow", overflow_o, 1'b0);

        // Full-size image: 64x64 of -1 with a single +1 at (1,63)
        do_clear(1'b1, 64);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                pixq.push_back((r == 1 && c == 63) ? 2'b01 : 2'b11);
        build_expected(1'b1, 64);
        run_stream(0);
        if (outq.size() > 31) begin
            chk("big out[31]", outq[31], 2'b01);
            chk("big out[0]", outq[0], 2'b11);
        end else begin
            chk("big too few outputs", outq.size(), 1024);
        end
        compare_out("big 64x64");
        chk("big overflow", overflow_o, 1'b0);

        // Randomized images against the window model
        for (int k = 0; k < 16; k++) begin
            bit pool;
            int w;
            int rows;
            pool = ($urandom_range(0, 3) != 0);
            w    = 2 * $urandom_range(1, 32);
            rows = 2 * $urandom_range(1, 3);
            do_clear(pool, w);
            for (int i = 0; i < w * rows; i++) begin
                int r;
                r = $urandom_range(0, 9);
                pixq.push_back(r < 3 ? 2'b11 : r < 6 ? 2'b00 : r < 9 ? 2'b01 : 2'b10);
            end
            build_expected(pool, w);
            run_stream($urandom_range(0, 3));
            compare_out($sformatf("rand%0d pool=%0d w=%0d", k, pool, w));
            chk($sformatf("rand%0d overflow", k), overflow_o, 1'b0);
        end

        // Width 66 overfills the 32-entry FIFO; the 33rd push is dropped
        do_clear(1'b1, 66);
        for (int i = 0; i < 64; i++) px(2'b00);
        idle(2);
        chk("ovf after 32 pushes", overflow_o, 1'b0);
        px(2'b00); px(2'b00);
        idle(2);
        chk("ovf after 33rd push", overflow_o, 1'b1);
        for (int i = 0; i < 66; i++) px(2'b11);
        idle(4);
        chk("ovf row1 output count", outq.size(), 33);
        if (outq.size() == 33) begin
            chk("ovf row1 first", outq[0], 2'b00);
            chk("ovf row1 pop-empty last", outq[32], 2'b11);
        end
        outq.delete();
        chk("ovf sticky", overflow_o, 1'b1);

        // Asynchronous reset between clock edges
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst valid_o", valid_o, 1'b0);
        chk("async rst data_o", data_o, 2'b00);
        chk("async rst overflow_o", overflow_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
